// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe turn controller: cell marks, phases,
// FSM states, restart key default and the table of winning lines.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam int unsigned NumCells = 9;
  localparam int unsigned NumLines = 8;

  localparam logic [3:0] KEY_RESTART_DFLT = 4'd15;

  typedef enum logic [1:0] {
    PhaseIdle = 2'd0,
    PhasePlay = 2'd1,
    PhaseWin  = 2'd2,
    PhaseDraw = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StCheck,
    StWin,
    StDraw
  } state_e;

  // Cell indices (row-major) of the 3 rows, 3 columns and 2 diagonals.
  localparam int unsigned LINE_TBL [NumLines][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

endpackage

// File: rtl/win_detect.sv
// Combinational line detector: flags when any of the 8 lines is fully
// occupied by the given mark.
module win_detect
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  mark,
  output logic        win
);

  always_comb begin
    win = 1'b0;
    for (int l = 0; l < NumLines; l++) begin
      if ((board[2*LINE_TBL[l][0] +: 2] == mark) &&
          (board[2*LINE_TBL[l][1] +: 2] == mark) &&
          (board[2*LINE_TBL[l][2] +: 2] == mark)) begin
        win = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Tic-tac-toe turn controller: accepts keypad moves, alternates players,
// rejects illegal moves and resolves win/draw one cycle after each move.
module turn_controller
  import ttt_pkg::*;
#(
  parameter logic [3:0] KEY_RESTART = KEY_RESTART_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        start,
  output logic [17:0] board,
  output logic        is_turn_o,
  output logic [1:0]  phase,
  output logic [1:0]  winner,
  output logic        illegal,
  output logic [3:0]  move_count
);

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic [1:0]  winner_q, winner_d;
  logic        illegal_q, illegal_d;
  logic [3:0]  count_q, count_d;

  logic [1:0]  mark;
  logic        win;
  logic        restart_key;
  logic        key_cell;
  logic        cell_empty;
  logic        do_clear;

  assign mark = turn_q ? CELL_O : CELL_X;

  // A concurrent start always wins, so the key is treated as absent.
  assign restart_key = key_valid && !start && (key_code == KEY_RESTART);
  assign key_cell    = (key_code < 4'd9);

  always_comb begin
    cell_empty = 1'b0;
    for (int i = 0; i < NumCells; i++) begin
      if (key_code == 4'(i)) begin
        cell_empty = (board_q[2*i +: 2] == CELL_EMPTY);
      end
    end
  end

  win_detect u_win_detect (
    .board (board_q),
    .mark  (mark),
    .win   (win)
  );

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    winner_d  = winner_q;
    count_d   = count_q;
    illegal_d = 1'b0;
    do_clear  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) do_clear = 1'b1;
      end
      StPlay: begin
        if (restart_key) begin
          do_clear = 1'b1;
        end else if (key_valid && !start) begin
          if (key_cell && cell_empty) begin
            for (int i = 0; i < NumCells; i++) begin
              if (key_code == 4'(i)) board_d[2*i +: 2] = mark;
            end
            count_d = count_q + 4'd1;
            state_d = StCheck;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StCheck: begin
        // Win is tested first so a winning 9th move is not reported as a draw.
        if (restart_key) begin
          do_clear = 1'b1;
        end else if (win) begin
          winner_d = mark;
          state_d  = StWin;
        end else if (count_q == 4'd9) begin
          state_d = StDraw;
        end else begin
          turn_d  = ~turn_q;
          state_d = StPlay;
        end
      end
      StWin, StDraw: begin
        if (start || restart_key) do_clear = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (do_clear) begin
      board_d  = '0;
      turn_d   = 1'b0;
      winner_d = CELL_EMPTY;
      count_d  = 4'd0;
      state_d  = StPlay;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      board_q   <= '0;
      turn_q    <= 1'b0;
      winner_q  <= CELL_EMPTY;
      illegal_q <= 1'b0;
      count_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      winner_q  <= winner_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    case (state_q)
      StPlay, StCheck: phase = PhasePlay;
      StWin:           phase = PhaseWin;
      StDraw:          phase = PhaseDraw;
      default:         phase = PhaseIdle;
    endcase
  end

  assign board      = board_q;
  assign is_turn_o  = turn_q;
  assign winner     = winner_q;
  assign illegal    = illegal_q;
  assign move_count = count_q;

endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 The block SHALL have parameter KEY_RESTART, default 4'd15, the key code that restarts the game.
REQ-002 The block SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port key_valid  in  1  one-cycle pulse, debounced keypad press.
REQ-005 The block SHALL have port key_code  in  4  cell index 0-8 (row-major), or KEY_RESTART; other codes are invalid.
REQ-006 The block SHALL have port start  in  1  one-cycle pulse from the main menu.
REQ-007 The block SHALL have port board  out  18  cell i at bits [2i+1:2i]; 00 empty, 01 X (P1), 10 O (P2); 11 never driven.
REQ-008 The block SHALL have port is_turn_o  out  1  0 = P1/X to move, 1 = P2/O to move.
REQ-009 The block SHALL have port phase  out  2  0 IDLE, 1 PLAY, 2 WIN, 3 DRAW.
REQ-010 The block SHALL have port winner  out  2  01 X, 10 O, 00 none.
REQ-011 The block SHALL have port illegal  out  1  one-cycle pulse on a rejected move.
REQ-012 The block SHALL have port move_count  out  4  number of occupied cells, 0-9.

Function
REQ-013 FSM states SHALL be IDLE, PLAY, CHECK, WIN, DRAW; phase reports CHECK as PLAY.
REQ-014 IDLE: start -> clear board, move_count 0, is_turn_o 0, winner 00, enter PLAY next cycle.
REQ-015 PLAY: key_valid with key_code 0-8 and an empty cell -> cell written with the mover's mark and move_count incremented at edge N+1, enter CHECK.
REQ-016 CHECK: one cycle; evaluate 8 lines (3 rows, 3 columns, 2 diagonals) for the mover's mark only.
REQ-017 CHECK result: line complete -> WIN, winner = mover; else move_count==9 -> DRAW; else toggle is_turn_o and return to PLAY; all outputs settle at edge N+2.
REQ-018 PLAY: key_valid on an occupied cell, or key_code 9-14 (excluding KEY_RESTART) -> illegal high for exactly one cycle at N+1; board, turn and count unchanged.
REQ-019 key_valid during CHECK, WIN or DRAW (except KEY_RESTART) SHALL be ignored silently; no illegal pulse.
REQ-020 KEY_RESTART in PLAY, CHECK, WIN or DRAW -> same clear as REQ-014, enter PLAY; in IDLE it SHALL be ignored.
REQ-021 start in WIN or DRAW SHALL act as KEY_RESTART; start in PLAY or CHECK SHALL be ignored.
REQ-022 Simultaneous start and key_valid: start SHALL take priority and the key SHALL be dropped.
REQ-023 A win on the 9th move SHALL report WIN, not DRAW.
REQ-024 move_count SHALL never exceed 9; no write occurs after WIN or DRAW.

Reset
REQ-025 On rst assertion, all outputs SHALL clear immediately: board 0, is_turn_o 0, phase IDLE, winner 00, illegal 0, move_count 0.
REQ-026 rst asserted during CHECK SHALL discard the pending evaluation; after deassertion the block SHALL wait for start.

Structure
REQ-027 Package ttt_pkg SHALL hold the cell encodings (EMPTY, X, O), phase encodings, KEY_RESTART default and the 8-entry line index table.
REQ-028 Sub-module win_detect SHALL be combinational: inputs board (18) and mark (2); output win (1). It SHALL be instantiated once.

Verification
REQ-029 Test 1: rst, start, X at keys 0, 4, 8 with O at keys 1, 2 -> after the 5th move phase=WIN, winner=01, board bits 1:0, 9:8 and 17:16 are 01.
REQ-030 Test 2: a 9-move fill with no line (X:0,2,3,7,8; O:1,4,5,6) -> phase=DRAW, move_count=9, winner=00.
REQ-031 Test 3: key 4 twice -> second press pulses illegal for one cycle; is_turn_o stays 1; move_count stays 1.
REQ-032 Test 4: key_code 11 in PLAY -> illegal pulse; key 0 in WIN -> no change and no pulse.
REQ-033 Test 5: KEY_RESTART mid-game at move_count 5 -> board 0, move_count 0, is_turn_o 0, phase PLAY.
REQ-034 Test 6: rst asserted in the CHECK cycle -> outputs zero before the next edge; key presses are ignored until start.
